// File: rtl/audio_pkg.sv
// Shared encodings and saturation helpers for the audio loop recorder.
package audio_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRecord  = 2'b01,
    StPlay    = 2'b10,
    StOverdub = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ModeNone    = 2'b00,
    ModeRecord  = 2'b01,
    ModePlay    = 2'b10,
    ModeOverdub = 2'b11
  } mode_e;

  // Largest and smallest two's-complement values representable in w bits.
  function automatic longint sat_hi(int unsigned w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/audio_loop_recorder_if.sv
// Codec-side sample stream: per-channel ADC valid / DAC request pulses plus sample data.
interface audio_loop_recorder_if #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned NCH      = 2
);
  logic [NCH-1:0]      sample_end;
  logic [NCH-1:0]      sample_req;
  logic [SAMPLE_W-1:0] audio_input;
  logic [SAMPLE_W-1:0] audio_output;

  modport master (
    output sample_end,
    output sample_req,
    output audio_input,
    input  audio_output
  );

  modport slave (
    input  sample_end,
    input  sample_req,
    input  audio_input,
    output audio_output
  );
endinterface

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a registered read.
module sample_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WORDS = 16384,
  parameter int unsigned AW    = 14
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/audio_loop_recorder.sv
// Loop recorder: records a take into sample_ram, plays it back (optionally looped), else passthrough.
// Define AUDIO_LOOP_OVERDUB_EN to enable saturating overdub in mode 11.
module audio_loop_recorder
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned NCH      = 2,
  parameter int unsigned DEPTH    = 8192,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  audio_loop_recorder_if.slave aud,
  input  logic [1:0]           mode,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop_en,
  output logic                 busy,
  output logic                 full,
  output logic [AW:0]          rec_len,
  output logic [1:0]           state
);

  localparam int unsigned CSH   = (NCH > 1) ? $clog2(NCH) : 0;
  localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned ADW   = AW + CSH;
  localparam int unsigned WORDS = NCH * DEPTH;
  localparam logic [AW-1:0] PtrMax  = AW'(DEPTH - 1);
  localparam logic [AW:0]   LenFull = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] ChLast  = CW'(NCH - 1);

  function automatic logic [ADW-1:0] frame_addr(logic [AW-1:0] f, logic [CW-1:0] c);
    return (ADW'(f) << CSH) | ADW'(c);
  endfunction

  state_e              state_q, state_d, play_st;
  mode_e               mode_s;
  logic [AW-1:0]       ptr_q;
  logic [AW:0]         ptr_inc;
  logic [AW:0]         rec_len_q;
  logic                full_q;
  logic                end_hit, req_hit, end_last, req_last, playing, start_ok;
  logic [CW-1:0]       end_ch, req_ch;
  logic                we, re;
  logic [ADW-1:0]      waddr, raddr;
  logic [SAMPLE_W-1:0] wdata, rd_data;
  logic                s1_vld_q, s1_ram_q;
  logic [SAMPLE_W-1:0] s1_pt_q, out_q;
  logic [SAMPLE_W-1:0] pt_q [NCH];

  assign mode_s   = mode_e'(mode);
  assign start_ok = start && !stop;
  assign playing  = (state_q == StPlay) || (state_q == StOverdub);
  assign ptr_inc  = {1'b0, ptr_q} + 1'b1;

  // Only the lowest set bit of each pulse vector is served.
  always_comb begin
    end_hit = 1'b0;
    end_ch  = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (aud.sample_end[i]) begin
        end_hit = 1'b1;
        end_ch  = CW'(i);
      end
    end
  end

  always_comb begin
    req_hit = 1'b0;
    req_ch  = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (aud.sample_req[i]) begin
        req_hit = 1'b1;
        req_ch  = CW'(i);
      end
    end
  end

  assign end_last = end_hit && (end_ch == ChLast);
  assign req_last = req_hit && (req_ch == ChLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          if (mode_s == ModeRecord) begin
            state_d = StRecord;
          end else if ((mode_s == ModePlay || mode_s == ModeOverdub) && rec_len_q != '0) begin
            state_d = play_st;
          end
        end
      end
      StRecord: begin
        if (stop || (end_last && ptr_q == PtrMax)) state_d = StIdle;
      end
      StPlay: begin
        if (stop || (req_last && ptr_inc == rec_len_q && !loop_en)) state_d = StIdle;
      end
      StOverdub: begin
        if (stop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = (state_q != StIdle);
    state = state_q;
  end

  assign full             = full_q;
  assign rec_len          = rec_len_q;
  assign aud.audio_output = out_q;

  // Frame pointer, take length and full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      rec_len_q <= '0;
      full_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (state_d != StIdle) begin
            ptr_q <= '0;
            if (state_d == StRecord) full_q <= 1'b0;
          end
        end
        StRecord: begin
          if (stop) begin
            rec_len_q <= {1'b0, ptr_q};
            ptr_q     <= '0;
          end else if (end_last) begin
            if (ptr_q == PtrMax) begin
              full_q    <= 1'b1;
              rec_len_q <= LenFull;
              ptr_q     <= '0;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        default: begin
          if (stop) begin
            ptr_q <= '0;
          end else if (req_last) begin
            ptr_q <= (ptr_inc == rec_len_q) ? '0 : ptr_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Two-stage output path: stage 1 is the RAM read (or latch pick), stage 2 the DAC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_ram_q <= 1'b0;
      s1_pt_q  <= '0;
      out_q    <= '0;
      for (int i = 0; i < int'(NCH); i++) pt_q[i] <= '0;
    end else begin
      s1_vld_q <= req_hit && (playing || state_q == StIdle);
      s1_ram_q <= playing;
      s1_pt_q  <= pt_q[req_ch];
      if (state_q == StIdle && end_hit) pt_q[end_ch] <= aud.audio_input;
      if (s1_vld_q) out_q <= s1_ram_q ? rd_data : s1_pt_q;
    end
  end

  assign re    = req_hit && playing;
  assign raddr = frame_addr(ptr_q, req_ch);
  assign waddr = frame_addr(ptr_q, end_ch);

`ifdef AUDIO_LOOP_OVERDUB_EN
  localparam logic [SAMPLE_W-1:0] SatHi = SAMPLE_W'(sat_hi(SAMPLE_W));
  localparam logic [SAMPLE_W-1:0] SatLo = SAMPLE_W'(sat_lo(SAMPLE_W));

  logic [SAMPLE_W-1:0] last_rd_q [NCH];
  logic [CW-1:0]       s1_ch_q;
  logic [SAMPLE_W:0]   od_sum;
  logic [SAMPLE_W-1:0] od_sat;

  assign play_st = (mode_s == ModeOverdub) ? StOverdub : StPlay;

  // Sign-extended sum; overflow shows as disagreement of the top two bits.
  always_comb begin
    od_sum = {last_rd_q[end_ch][SAMPLE_W-1], last_rd_q[end_ch]}
           + {aud.audio_input[SAMPLE_W-1], aud.audio_input};
    if (od_sum[SAMPLE_W] != od_sum[SAMPLE_W-1]) begin
      od_sat = od_sum[SAMPLE_W] ? SatLo : SatHi;
    end else begin
      od_sat = od_sum[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_ch_q <= '0;
      for (int i = 0; i < int'(NCH); i++) last_rd_q[i] <= '0;
    end else begin
      s1_ch_q <= req_ch;
      if (s1_vld_q && s1_ram_q) last_rd_q[s1_ch_q] <= rd_data;
    end
  end

  assign we    = end_hit && (state_q == StRecord || state_q == StOverdub);
  assign wdata = (state_q == StOverdub) ? od_sat : aud.audio_input;
`else
  assign play_st = StPlay;
  assign we      = end_hit && (state_q == StRecord);
  assign wdata   = aud.audio_input;
`endif

  sample_ram #(
    .WIDTH (SAMPLE_W),
    .WORDS (WORDS),
    .AW    (ADW)
  ) u_sample_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rd_data)
  );

endmodule

// File: doc/audio_loop_recorder.md
AUDIO_LOOP_RECORDER -- requirements
Module: audio_loop_recorder

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, signed PCM sample width.
REQ-002 SHALL have parameter NCH, default 2, channel count (power of two, >=1).
REQ-003 SHALL have parameter DEPTH, default 8192, buffer capacity in frames (power of two); AW = clog2(DEPTH).
REQ-004 SHALL have port clk, input, 1: single clock, the codec audio clock.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port sample_end, input, NCH: one-cycle pulse per channel, ADC sample valid on audio_input.
REQ-007 SHALL have port sample_req, input, NCH: one-cycle pulse per channel, DAC sample request.
REQ-008 SHALL have port audio_input, input, SAMPLE_W: ADC sample for the channel flagged by sample_end.
REQ-009 SHALL have port audio_output, output, SAMPLE_W: DAC sample, held between updates.
REQ-010 SHALL have port mode, input, 2: 01 record, 10 play, 11 overdub; sampled only on start.
REQ-011 SHALL have ports start and stop, input, 1 each: command pulses.
REQ-012 SHALL have port loop_en, input, 1: playback wraps at end of take.
REQ-013 SHALL have ports busy (1), full (1), rec_len (AW+1, frames recorded), state (2: 00 IDLE, 01 RECORD, 10 PLAY, 11 OVERDUB), all outputs.

Function
REQ-014 SHALL store sample of channel c, frame f at buffer address {f, c}.
REQ-015 SHALL, in IDLE, on start with mode 01, clear frame pointer, clear full, enter RECORD next cycle.
REQ-016 SHALL, in IDLE, on start with mode 10 or 11 and rec_len>0, clear frame pointer, enter PLAY or OVERDUB; rec_len==0 or mode 00 ignores start.
REQ-017 SHALL, in RECORD, write audio_input at {ptr, c} in the cycle sample_end[c] is seen; ptr increments on sample_end[NCH-1].
REQ-018 SHALL, when ptr wraps from DEPTH-1 in RECORD, set full=1, rec_len=DEPTH, return to IDLE.
REQ-019 SHALL, on stop in RECORD, set rec_len=ptr (completed frames only) and return to IDLE.
REQ-020 SHALL, on sample_req[c] in PLAY/OVERDUB, read {ptr, c} and update audio_output exactly 2 cycles later; ptr increments on sample_req[NCH-1].
REQ-021 SHALL, when ptr reaches rec_len in PLAY, wrap to 0 if loop_en else return to IDLE; OVERDUB always wraps.
REQ-022 SHALL, in IDLE, act as passthrough: latch audio_input per channel on sample_end[c], present it on audio_output 2 cycles after sample_req[c].
REQ-023 SHALL treat stop in PLAY/OVERDUB as immediate return to IDLE; stop in IDLE ignored; start and stop together: stop wins, start ignored.
REQ-024 SHALL serve only the lowest set bit if several sample_end (or sample_req) bits are set in one cycle; sample_end and sample_req in the same cycle are both served.
REQ-025 SHALL drive busy=1 whenever state != IDLE.

Reset
REQ-026 SHALL, on reset, set state IDLE, ptr 0, rec_len 0, full 0, busy 0, audio_output 0, passthrough latches 0; buffer contents undefined; reset mid-operation aborts without updating rec_len.

Configuration
REQ-027 SHALL, with AUDIO_LOOP_OVERDUB_EN defined, in OVERDUB write sat(stored{ptr,c} + audio_input) at {ptr,c} on sample_end[c], stored value being the last read for channel c; sum in SAMPLE_W+1 bits, clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
REQ-028 SHALL, without AUDIO_LOOP_OVERDUB_EN, treat mode 11 as mode 10; state 11 unreachable; no adder/saturation logic.

Structure
REQ-029 SHALL place state encoding, mode encoding and saturation limit helpers in shared package audio_pkg.
REQ-030 SHALL instantiate one sub-module sample_ram: simple dual-port (one write, one read), NCH*DEPTH x SAMPLE_W, 1-cycle registered read, no reset.

Verification (NCH=2, DEPTH=8, SAMPLE_W=16)
REQ-031 Record 3 frames L/R = 0x0100..0x0105, stop -> rec_len=3, state IDLE, full=0.
REQ-032 Play, loop_en=0 -> outputs 0x0100..0x0105 each 2 cycles after request, then IDLE and passthrough.
REQ-033 Record 9 frames without stop -> full=1, rec_len=8 after 8th frame, 9th sample not written.
REQ-034 Overdub (macro on) stored 0x7000 + input 0x2000 -> next loop plays 0x7FFF; stored 0x9000 + 0xA000 -> 0x8000.
REQ-035 start+stop same cycle in IDLE -> stays IDLE; reset asserted mid-RECORD -> rec_len=0, audio_output=0.
REQ-036 sample_end=2'b11 in RECORD -> only channel 0 written, ptr unchanged.
